// File: rtl/nvram_pkg.sv
// Shared constants for the NVRAM ioctl responder: FSM state codes, nibble
// selects within a byte, and the fill byte returned for unmapped addresses.
package nvram_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_RD_LO  = 3'd1;
    localparam state_t ST_CAP_LO = 3'd2;
    localparam state_t ST_RD_HI  = 3'd3;
    localparam state_t ST_CAP_HI = 3'd4;
    localparam state_t ST_WR_LO  = 3'd5;
    localparam state_t ST_WR_HI  = 3'd6;

    localparam logic NIB_LO = 1'b0;
    localparam logic NIB_HI = 1'b1;

    localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage

// File: rtl/nvram_ioctl_port.sv
// Saves/restores the 4-bit CMOS RAM over the HPS ioctl path, packing two
// nibbles per byte, and flags CMOS changes since the last save/restore.
//
// state   | meaning
// --------+--------------------------------------------------
// IDLE    | waiting for an ioctl_rd / ioctl_wr strobe
// RD_LO   | requesting low nibble (2n) read
// CAP_LO  | capturing low nibble from cmos_rdata
// RD_HI   | requesting high nibble (2n+1) read
// CAP_HI  | capturing high nibble, presenting ioctl_din
// WR_LO   | requesting low nibble write
// WR_HI   | requesting high nibble write
module nvram_ioctl_port
    import nvram_pkg::*;
#(
    parameter int          CMOS_AW  = 10,
    parameter logic [15:0] NV_INDEX = 16'd4
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               ioctl_upload,
    input  logic               ioctl_download,
    input  logic [15:0]        ioctl_index,
    input  logic [24:0]        ioctl_addr,
    input  logic               ioctl_rd,
    input  logic               ioctl_wr,
    input  logic [7:0]         ioctl_dout,
    output logic [7:0]         ioctl_din,
    output logic               ioctl_wait,
    output logic               cmos_req,
    input  logic               cmos_gnt,
    output logic [CMOS_AW-1:0] cmos_addr,
    output logic               cmos_we,
    output logic [3:0]         cmos_wdata,
    input  logic [3:0]         cmos_rdata,
    input  logic               cpu_cmos_we,
    output logic               nvram_dirty
);

    localparam int NV_BYTES = 2 ** (CMOS_AW - 1);

    state_t             state;
    logic [CMOS_AW-2:0] byte_addr;
    logic [7:0]         wr_byte;
    logic [3:0]         lo_nib;
    logic               oor_rd;
    logic               prev_upload;
    logic               prev_download;

    logic idx_match;
    logic acc_rd;
    logic acc_wr;
    logic in_range;
    logic nv_end;

    assign idx_match = (ioctl_index == NV_INDEX);
    assign acc_rd    = ioctl_rd & ioctl_upload & idx_match;
    assign acc_wr    = ioctl_wr & ioctl_download & idx_match;
    assign in_range  = (ioctl_addr < 25'(NV_BYTES));

    // Bus outputs decode straight from state so an async reset drops them at once.
    assign cmos_req  = (state == ST_RD_LO) | (state == ST_RD_HI) |
                       (state == ST_WR_LO) | (state == ST_WR_HI);
    assign cmos_we   = (state == ST_WR_LO) | (state == ST_WR_HI);
    assign cmos_addr = {byte_addr,
                        ((state == ST_RD_HI) || (state == ST_WR_HI)) ? NIB_HI : NIB_LO};

    always_comb begin
        cmos_wdata = 4'h0;
        if (state == ST_WR_LO) cmos_wdata = wr_byte[3:0];
        if (state == ST_WR_HI) cmos_wdata = wr_byte[7:4];
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            byte_addr  <= '0;
            wr_byte    <= 8'h00;
            lo_nib     <= 4'h0;
            oor_rd     <= 1'b0;
            ioctl_din  <= 8'h00;
            ioctl_wait <= 1'b0;
        end else begin
            oor_rd <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Wait high while idle only happens for the unmapped-address pulse.
                    if (ioctl_wait) begin
                        ioctl_wait <= 1'b0;
                        if (oor_rd) ioctl_din <= FILL_BYTE;
                    end else if (acc_rd) begin
                        ioctl_wait <= 1'b1;
                        if (in_range) begin
                            byte_addr <= ioctl_addr[CMOS_AW-2:0];
                            state     <= ST_RD_LO;
                        end else begin
                            oor_rd <= 1'b1;
                        end
                    end else if (acc_wr) begin
                        ioctl_wait <= 1'b1;
                        if (in_range) begin
                            byte_addr <= ioctl_addr[CMOS_AW-2:0];
                            wr_byte   <= ioctl_dout;
                            state     <= ST_WR_LO;
                        end
                    end
                end
                ST_RD_LO:  if (cmos_gnt) state <= ST_CAP_LO;
                ST_CAP_LO: begin
                    lo_nib <= cmos_rdata;
                    state  <= ST_RD_HI;
                end
                ST_RD_HI:  if (cmos_gnt) state <= ST_CAP_HI;
                ST_CAP_HI: begin
                    ioctl_din  <= {cmos_rdata, lo_nib};
                    ioctl_wait <= 1'b0;
                    state      <= ST_IDLE;
                end
                ST_WR_LO:  if (cmos_gnt) state <= ST_WR_HI;
                ST_WR_HI: begin
                    if (cmos_gnt) begin
                        ioctl_wait <= 1'b0;
                        state      <= ST_IDLE;
                    end
                end
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign nv_end = idx_match & ((prev_upload & ~ioctl_upload) |
                                 (prev_download & ~ioctl_download));

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            prev_upload   <= 1'b0;
            prev_download <= 1'b0;
            nvram_dirty   <= 1'b0;
        end else begin
            prev_upload   <= ioctl_upload;
            prev_download <= ioctl_download;
            if (cpu_cmos_we)  nvram_dirty <= 1'b1;
            else if (nv_end)  nvram_dirty <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nvram_ioctl_port.sv
// Scoreboard bench for nvram_ioctl_port: a CMOS model answers the request port,
// a reference nibble array predicts upload bytes and download effects.
module tb_nvram_ioctl_port;

    localparam int AW     = 10;
    localparam int NBYTES = 512;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_upload = 1'b0, ioctl_download = 1'b0;
    logic [15:0] ioctl_index = 16'd4;
    logic [24:0] ioctl_addr = '0;
    logic        ioctl_rd = 1'b0, ioctl_wr = 1'b0;
    logic [7:0]  ioctl_dout = 8'h00;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        cmos_req, cmos_gnt, cmos_we;
    logic [AW-1:0] cmos_addr;
    logic [3:0]  cmos_wdata;
    logic [3:0]  cmos_rdata = 4'h0;
    logic        cpu_cmos_we = 1'b0;
    logic        nvram_dirty;

    logic        gnt_rand = 1'b0, gnt_force = 1'b1, gnt_rnd_bit = 1'b1;
    assign cmos_gnt = gnt_rand ? gnt_rnd_bit : gnt_force;

    nvram_ioctl_port #(.CMOS_AW(AW), .NV_INDEX(16'd4)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_upload(ioctl_upload), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr),
        .ioctl_rd(ioctl_rd), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
        .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
        .cmos_req(cmos_req), .cmos_gnt(cmos_gnt), .cmos_addr(cmos_addr),
        .cmos_we(cmos_we), .cmos_wdata(cmos_wdata), .cmos_rdata(cmos_rdata),
        .cpu_cmos_we(cpu_cmos_we), .nvram_dirty(nvram_dirty)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // CMOS model: the environment memory, plus a backdoor used for preloading.
    logic [3:0] mem [1024];
    logic [3:0] ref_mem [1024];
    logic       pl_en = 1'b0;
    int         pl_addr = 0;
    logic [3:0] pl_data = 4'h0;

    always @(posedge clk_sys) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (cmos_req && cmos_gnt) begin
            if (cmos_we) mem[cmos_addr] <= cmos_wdata;
            else         cmos_rdata     <= mem[cmos_addr];
        end
    end

    always @(posedge clk_sys) begin
        #1 gnt_rnd_bit = ($urandom_range(0, 3) != 0);
    end

    typedef struct {
        bit         up;
        bit         oor;
        int         addr;
        logic [7:0] data;
        int         t0;
        int         lat;
    } exp_t;
    exp_t q[$];

    // Monitor: checks bus accesses against the pending transfer and pops on completion.
    logic    prev_wait = 1'b0, prev_req = 1'b0, prev_gnt = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    always @(negedge clk_sys) begin
        if (reset) begin
            prev_wait = 1'b0;
            prev_req  = 1'b0;
        end else begin
            if (cmos_req) begin
                if (q.size() == 0 || q[0].oor) chk("req_unexpected", 32'(cmos_req), 32'd0);
                else begin
                    chk("cmos_addr_byte", 32'(cmos_addr >> 1), 32'(q[0].addr));
                    chk("cmos_we", 32'(cmos_we), 32'(!q[0].up));
                    if (cmos_we)
                        chk("cmos_wdata", 32'(cmos_wdata),
                            cmos_addr[0] ? 32'(q[0].data[7:4]) : 32'(q[0].data[3:0]));
                end
                if (prev_req && !prev_gnt) chk("cmos_addr_stable", 32'(cmos_addr), 32'(prev_addr));
            end
            if (ioctl_wait && !prev_wait) begin
                if (q.size() == 0) chk("wait_unexpected", 32'(ioctl_wait), 32'd0);
                else               chk("wait_rise_lat", 32'(cyc - q[0].t0), 32'd1);
            end
            if (!ioctl_wait && prev_wait && q.size() != 0) begin
                exp_t e;
                e = q.pop_front();
                if (e.lat >= 0) chk("wait_fall_lat", 32'(cyc - e.t0), 32'(e.lat));
                if (e.up) chk("ioctl_din", 32'(ioctl_din), 32'(e.data));
            end
            prev_wait = ioctl_wait;
            prev_req  = cmos_req;
            prev_gnt  = cmos_gnt;
            prev_addr = cmos_addr;
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic start_xfer(bit up, int addr, logic [7:0] data, int lat);
        exp_t e;
        e.up   = up;
        e.oor  = (addr >= NBYTES);
        e.addr = addr;
        e.data = data;
        if (up) e.data = e.oor ? 8'hFF : {ref_mem[2*addr+1], ref_mem[2*addr]};
        else if (!e.oor) begin
            ref_mem[2*addr]   = data[3:0];
            ref_mem[2*addr+1] = data[7:4];
        end
        e.lat = lat;
        e.t0  = cyc;
        ioctl_index = 16'd4;
        if (up) ioctl_upload = 1'b1; else ioctl_download = 1'b1;
        ioctl_addr = 25'(addr);
        ioctl_dout = data;
        if (up) ioctl_rd = 1'b1; else ioctl_wr = 1'b1;
        q.push_back(e);
        tick();
        ioctl_rd = 1'b0;
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk_sys);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: transfer still pending after %0d cycles", n);
            q.delete();
        end
        tick();
    endtask

    task automatic xfer(bit up, int addr, logic [7:0] data, int lat);
        start_xfer(up, addr, data, lat);
        wait_done();
    endtask

    task automatic end_session();
        ioctl_index    = 16'd4;
        ioctl_upload   = 1'b0;
        ioctl_download = 1'b0;
        tick();
    endtask

    task automatic pulse_cpu_we();
        cpu_cmos_we = 1'b1;
        tick();
        cpu_cmos_we = 1'b0;
        tick();
    endtask

    initial begin
        logic [3:0] save40, save41;
        int bad;
        int a;
        bit up;

        // Preload CMOS with random nibbles while reset is held.
        for (int i = 0; i < 1024; i++) begin
            pl_en   = 1'b1;
            pl_addr = i;
            pl_data = 4'($urandom_range(0, 15));
            if (i == 0) pl_data = 4'h3;
            if (i == 1) pl_data = 4'hA;
            ref_mem[i] = pl_data;
            tick();
        end
        pl_en = 1'b0;
        @(negedge clk_sys);
        chk("rst_din", 32'(ioctl_din), 32'h00);
        chk("rst_wait", 32'(ioctl_wait), 32'd0);
        chk("rst_req", 32'(cmos_req), 32'd0);
        chk("rst_we", 32'(cmos_we), 32'd0);
        chk("rst_addr", 32'(cmos_addr), 32'd0);
        chk("rst_wdata", 32'(cmos_wdata), 32'd0);
        chk("rst_dirty", 32'(nvram_dirty), 32'd0);
        reset = 1'b0;
        tick();

        // Basic upload and download with grant held high.
        xfer(1'b1, 0, 8'h00, 5);
        chk("upload_0_din", 32'(ioctl_din), 32'hA3);
        xfer(1'b0, 7, 8'h5C, 3);
        chk("dl_nib14", 32'(mem[14]), 32'hC);
        chk("dl_nib15", 32'(mem[15]), 32'h5);
        chk("dl_nib13", 32'(mem[13]), 32'(ref_mem[13]));
        chk("dl_nib16", 32'(mem[16]), 32'(ref_mem[16]));
        xfer(1'b1, 7, 8'h00, 5);

        // Grant withheld for 3 cycles while in RD_HI.
        start_xfer(1'b1, 0, 8'h00, 8);
        tick();
        tick();
        gnt_force = 1'b0;
        tick();
        tick();
        tick();
        gnt_force = 1'b1;
        wait_done();

        // Unmapped addresses.
        xfer(1'b1, 512, 8'h00, 2);
        chk("oor_din", 32'(ioctl_din), 32'hFF);
        xfer(1'b0, 600, 8'h12, 2);
        xfer(1'b1, 1 << 24, 8'h00, 2);

        // Strobe with a non-NVRAM index must be ignored.
        ioctl_index  = 16'd0;
        ioctl_upload = 1'b1;
        ioctl_addr   = 25'd3;
        ioctl_rd     = 1'b1;
        tick();
        ioctl_rd = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        chk("idx0_wait", 32'(ioctl_wait), 32'd0);
        chk("idx0_din", 32'(ioctl_din), 32'hFF);
        end_session();

        // Dirty tracking.
        chk("dirty_after_end", 32'(nvram_dirty), 32'd0);
        pulse_cpu_we();
        chk("dirty_set", 32'(nvram_dirty), 32'd1);
        ioctl_upload = 1'b1;
        tick();
        end_session();
        chk("dirty_clr_upload", 32'(nvram_dirty), 32'd0);
        pulse_cpu_we();
        ioctl_upload = 1'b1;
        tick();
        ioctl_upload = 1'b0;
        cpu_cmos_we  = 1'b1;
        tick();
        cpu_cmos_we = 1'b0;
        tick();
        chk("dirty_set_wins", 32'(nvram_dirty), 32'd1);
        ioctl_download = 1'b1;
        tick();
        end_session();
        chk("dirty_clr_download", 32'(nvram_dirty), 32'd0);

        // Reset while a download sits in WR_LO.
        save40    = ref_mem[40];
        save41    = ref_mem[41];
        gnt_force = 1'b0;
        start_xfer(1'b0, 20, 8'h96, -1);
        @(negedge clk_sys);
        reset = 1'b1;
        #1;
        chk("rst_abort_req", 32'(cmos_req), 32'd0);
        chk("rst_abort_we", 32'(cmos_we), 32'd0);
        chk("rst_abort_wait", 32'(ioctl_wait), 32'd0);
        q.delete();
        ref_mem[40] = save40;
        ref_mem[41] = save41;
        end_session();
        gnt_force = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("rst_abort_nib40", 32'(mem[40]), 32'(save40));
        chk("rst_abort_nib41", 32'(mem[41]), 32'(save41));

        // Randomized transfers, mixing held and random grant.
        for (int i = 0; i < 80; i++) begin
            up = 1'($urandom_range(0, 1));
            a  = ($urandom_range(0, 9) == 0) ? 512 + int'($urandom_range(0, 4000))
                                             : int'($urandom_range(0, NBYTES - 1));
            gnt_rand = 1'($urandom_range(0, 1));
            if (a >= NBYTES)  xfer(up, a, 8'($urandom), 2);
            else if (gnt_rand) xfer(up, a, 8'($urandom), -1);
            else              xfer(up, a, 8'($urandom), up ? 5 : 3);
            if ($urandom_range(0, 3) == 0) end_session();
        end
        gnt_rand = 1'b0;
        end_session();
        chk("dirty_final", 32'(nvram_dirty), 32'd0);

        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("mem_final_mismatches", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
